// File: rtl/jac_pkg.sv
// jac_pkg: opcode map, FSM state encoding and instruction field layout.
// These are shared by the control unit and by ALU_J users.
package jac_pkg;

  localparam int unsigned InstrWidth = 16;
  localparam int unsigned OpcodeBits = 5;
  localparam int unsigned RegIdxBits = 3;
  localparam int unsigned FieldBits  = 8;
  localparam int unsigned NumRegs    = 8;
  localparam int unsigned StatusBits = 2;

  // Instruction layout: [15:11] opcode, [10:8] rd, [7:0] param
  typedef struct packed {
    logic [OpcodeBits-1:0] opcode;
    logic [RegIdxBits-1:0] rd;
    logic [FieldBits-1:0]  param;
  } instr_t;

  localparam logic [OpcodeBits-1:0] OP_NOP  = 5'h00;
  localparam logic [OpcodeBits-1:0] OP_ADD  = 5'h01;
  localparam logic [OpcodeBits-1:0] OP_SUB  = 5'h02;
  localparam logic [OpcodeBits-1:0] OP_AND  = 5'h03;
  localparam logic [OpcodeBits-1:0] OP_OR   = 5'h04;
  localparam logic [OpcodeBits-1:0] OP_XOR  = 5'h05;
  localparam logic [OpcodeBits-1:0] OP_NOT  = 5'h06;
  localparam logic [OpcodeBits-1:0] OP_SHL  = 5'h07;
  localparam logic [OpcodeBits-1:0] OP_SHR  = 5'h08;
  localparam logic [OpcodeBits-1:0] OP_VAL  = 5'h09;
  localparam logic [OpcodeBits-1:0] OP_GOTO = 5'h10;
  localparam logic [OpcodeBits-1:0] OP_IFZ  = 5'h11;
  localparam logic [OpcodeBits-1:0] OP_IFNZ = 5'h12;
  localparam logic [OpcodeBits-1:0] OP_IFEQ = 5'h13;
  localparam logic [OpcodeBits-1:0] OP_IFST = 5'h14;
  localparam logic [OpcodeBits-1:0] OP_IFGT = 5'h15;

  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_FETCH   = 2'd0;
  localparam logic [1:0] ST_DECODE  = 2'd1;
  localparam logic [1:0] ST_EXECUTE = 2'd2;
  localparam logic [1:0] ST_HALT    = 2'd3;

endpackage

// File: rtl/jac_control_unit_if.sv
// jac_control_unit_if: program-memory fetch bus, ALU bus and core status.
// master = control unit, slave = memory/ALU side.
interface jac_control_unit_if #(
  parameter int unsigned DataWidth     = 8,
  parameter int unsigned NumOpCodeBits = 5,
  parameter int unsigned ParamBits     = 8,
  parameter int unsigned AddrWidth     = 8
);
  logic                     prog_req;
  logic [AddrWidth-1:0]     prog_addr;
  logic [15:0]              prog_data;
  logic                     prog_valid;
  logic [NumOpCodeBits-1:0] alu_opcode;
  logic [DataWidth-1:0]     alu_operand1;
  logic [DataWidth-1:0]     alu_operand2;
  logic [ParamBits-1:0]     alu_param;
  logic [DataWidth-1:0]     alu_result;
  logic [1:0]               alu_status;
  logic [AddrWidth-1:0]     pc;
  logic                     halted;
  logic                     illegal_op;
  logic [1:0]               status;

  modport master (
    output prog_req, prog_addr, alu_opcode, alu_operand1, alu_operand2, alu_param,
           pc, halted, illegal_op, status,
    input  prog_data, prog_valid, alu_result, alu_status
  );

  modport slave (
    input  prog_req, prog_addr, alu_opcode, alu_operand1, alu_operand2, alu_param,
           pc, halted, illegal_op, status,
    output prog_data, prog_valid, alu_result, alu_status
  );
endinterface

// File: rtl/jac_regfile.sv
// jac_regfile: 8 x DataWidth register file, two async reads, one sync write.
module jac_regfile
  import jac_pkg::*;
#(
  parameter int unsigned DataWidth = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [RegIdxBits-1:0] raddr_a,
  input  logic [RegIdxBits-1:0] raddr_b,
  output logic [DataWidth-1:0]  rdata_a_c,
  output logic [DataWidth-1:0]  rdata_b_c,
  input  logic                  we,
  input  logic [RegIdxBits-1:0] waddr,
  input  logic [DataWidth-1:0]  wdata
);
  logic [DataWidth-1:0] regs [NumRegs];

  // Storage: cleared by reset, single write port
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NumRegs); i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a_c = regs[raddr_a];
  assign rdata_b_c = regs[raddr_b];
endmodule

// File: rtl/jac_control_unit.sv
// jac_control_unit: FETCH/DECODE/EXECUTE sequencer for the JAC core.
// Optional build macro JAC_HALT_ON_ILLEGAL_EN: reserved opcodes halt the core
// and pulse illegal_op; otherwise they execute as NOP.
module jac_control_unit
  import jac_pkg::*;
#(
  parameter int unsigned DataWidth     = 8,
  parameter int unsigned NumOpCodeBits = 5,
  parameter int unsigned ParamBits     = 8,
  parameter int unsigned AddrWidth     = 8
) (
  input logic                clock,
  input logic                reset,
  jac_control_unit_if.master bus
);
  state_t                   state_q, state_d;
  logic [AddrWidth-1:0]     pc_q, pc_d;
  instr_t                   instr_q, instr_d;
  logic                     prog_req_q, prog_req_d;
  logic [DataWidth-1:0]     r0_q, r0_d;
  logic [NumOpCodeBits-1:0] alu_opcode_q, alu_opcode_d;
  logic [DataWidth-1:0]     op1_q, op1_d, op2_q, op2_d;
  logic [ParamBits-1:0]     param_q, param_d;
  logic [StatusBits-1:0]    status_q, status_d;
  logic                     halted_q, halted_d;
  logic                     illegal_q, illegal_d;
  logic [RegIdxBits-1:0]    raddr_b;
  logic [DataWidth-1:0]     rdata_a_c, rdata_b_c;
  logic                     rf_we;
  logic [DataWidth-1:0]     rf_wdata;
  logic [AddrWidth-1:0]     target;

  // Port B reads R0 during FETCH (branch compare reference), R[param] in DECODE
  assign raddr_b = (state_q == ST_DECODE) ? instr_q.param[RegIdxBits-1:0] : '0;
  assign target  = AddrWidth'(instr_q.param);

  jac_regfile #(.DataWidth(DataWidth)) u_regfile (
    .clock     (clock),
    .reset     (reset),
    .raddr_a   (instr_q.rd),
    .raddr_b   (raddr_b),
    .rdata_a_c (rdata_a_c),
    .rdata_b_c (rdata_b_c),
    .we        (rf_we),
    .waddr     (instr_q.rd),
    .wdata     (rf_wdata)
  );

  // Next-state, datapath and registered-output values
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    prog_req_d   = prog_req_q;
    r0_d         = r0_q;
    alu_opcode_d = '0;
    op1_d        = op1_q;
    op2_d        = op2_q;
    param_d      = param_q;
    status_d     = status_q;
    halted_d     = halted_q;
    illegal_d    = 1'b0;
    rf_we        = 1'b0;
    rf_wdata     = '0;
    case (state_q)
      ST_FETCH: begin
        prog_req_d = 1'b1;
        r0_d       = rdata_b_c;
        if (prog_req_q && bus.prog_valid) begin
          instr_d    = instr_t'(bus.prog_data);
          prog_req_d = 1'b0;
          state_d    = ST_DECODE;
        end
      end
      ST_DECODE: begin
        op1_d        = rdata_a_c;
        op2_d        = rdata_b_c;
        param_d      = ParamBits'(instr_q.param);
        alu_opcode_d = NumOpCodeBits'(instr_q.opcode);
        state_d      = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        state_d    = ST_FETCH;
        prog_req_d = 1'b1;
        pc_d       = pc_q + AddrWidth'(1);
        case (instr_q.opcode)
          OP_NOP: ;
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR: begin
            rf_we    = 1'b1;
            rf_wdata = bus.alu_result;
            status_d = bus.alu_status;
          end
          OP_VAL: begin
            rf_we    = 1'b1;
            rf_wdata = DataWidth'(instr_q.param);
          end
          OP_GOTO: pc_d = target;
          OP_IFZ:  if (op1_q == '0)   pc_d = target;
          OP_IFNZ: if (op1_q != '0)   pc_d = target;
          OP_IFEQ: if (op1_q == r0_q) pc_d = target;
          OP_IFST: if (op1_q <  r0_q) pc_d = target;
          OP_IFGT: if (op1_q >  r0_q) pc_d = target;
          default: begin
`ifdef JAC_HALT_ON_ILLEGAL_EN
            state_d    = ST_HALT;
            prog_req_d = 1'b0;
            pc_d       = pc_q;
            halted_d   = 1'b1;
            illegal_d  = 1'b1;
`endif
          end
        endcase
      end
      ST_HALT: prog_req_d = 1'b0;
      default: state_d = ST_FETCH;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_FETCH;
      pc_q         <= '0;
      instr_q      <= '0;
      prog_req_q   <= 1'b0;
      r0_q         <= '0;
      alu_opcode_q <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      param_q      <= '0;
      status_q     <= '0;
      halted_q     <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      prog_req_q   <= prog_req_d;
      r0_q         <= r0_d;
      alu_opcode_q <= alu_opcode_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      param_q      <= param_d;
      status_q     <= status_d;
      halted_q     <= halted_d;
      illegal_q    <= illegal_d;
    end
  end

  assign bus.prog_req     = prog_req_q;
  assign bus.prog_addr    = pc_q;
  assign bus.pc           = pc_q;
  assign bus.alu_opcode   = alu_opcode_q;
  assign bus.alu_operand1 = op1_q;
  assign bus.alu_operand2 = op2_q;
  assign bus.alu_param    = param_q;
  assign bus.status       = status_q;
  assign bus.halted       = halted_q;
  assign bus.illegal_op   = illegal_q;
endmodule

// File: tb/tb_jac_control_unit.sv
// tb_jac_control_unit: directed and random instruction streams checked
// against an instruction-level model of the JAC machine.
module tb_jac_control_unit;
  localparam int unsigned DW = 8;
  localparam int unsigned OW = 5;
  localparam int unsigned PW = 8;
  localparam int unsigned AW = 8;

  logic clock = 1'b0;
  logic reset;

  jac_control_unit_if #(.DataWidth(DW), .NumOpCodeBits(OW), .ParamBits(PW), .AddrWidth(AW)) bus ();

  jac_control_unit #(.DataWidth(DW), .NumOpCodeBits(OW), .ParamBits(PW), .AddrWidth(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Instruction-level machine state
  logic [7:0] m_r [8];
  logic [1:0] m_st;
  logic [7:0] m_pc;
  logic       m_halt;
  logic       m_ill;
  logic [7:0] last_op1;

  // ALU behaviour: result and {underflow, carry}
  function automatic logic [9:0] alu_fn(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (op)
      5'h01:   return {1'b0, s[8], s[7:0]};
      5'h02:   return {(a < b), 1'b0, 8'(a - b)};
      5'h03:   return {2'b00, a & b};
      5'h04:   return {2'b00, a | b};
      5'h05:   return {2'b00, a ^ b};
      5'h06:   return {2'b00, ~a};
      5'h07:   return {1'b0, a[7], a[6:0], 1'b0};
      5'h08:   return {1'b0, a[0], 1'b0, a[7:1]};
      default: return 10'h000;
    endcase
  endfunction

  always_comb begin
    {bus.alu_status, bus.alu_result} = alu_fn(bus.alu_opcode, bus.alu_operand1, bus.alu_operand2);
  end

  function automatic logic [15:0] enc(input logic [4:0] op, input logic [2:0] rd, input logic [7:0] prm);
    return {op, rd, prm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
    m_st = 2'b00; m_pc = 8'h00; m_halt = 1'b0; m_ill = 1'b0;
  endtask

  // Architectural effect of one instruction
  task automatic model_step(input logic [15:0] ins);
    logic [4:0] op;
    logic [2:0] rd;
    logic [7:0] prm, a, nxt;
    logic [9:0] r;
    op = ins[15:11]; rd = ins[10:8]; prm = ins[7:0];
    a = m_r[rd];
    nxt = m_pc + 8'd1;
    m_ill = 1'b0;
    if (op >= 5'h01 && op <= 5'h08) begin
      r = alu_fn(op, a, m_r[prm[2:0]]);
      m_r[rd] = r[7:0];
      m_st = r[9:8];
    end else if (op == 5'h09) m_r[rd] = prm;
    else if (op == 5'h10) nxt = prm;
    else if (op == 5'h11) begin if (a == 8'h00) nxt = prm; end
    else if (op == 5'h12) begin if (a != 8'h00) nxt = prm; end
    else if (op == 5'h13) begin if (a == m_r[0]) nxt = prm; end
    else if (op == 5'h14) begin if (a < m_r[0]) nxt = prm; end
    else if (op == 5'h15) begin if (a > m_r[0]) nxt = prm; end
    else if (op != 5'h00) begin
`ifdef JAC_HALT_ON_ILLEGAL_EN
      m_halt = 1'b1; m_ill = 1'b1; nxt = m_pc;
`endif
    end
    m_pc = nxt;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    chk("rst_prog_req", 32'(bus.prog_req), 32'(0));
    chk("rst_pc", 32'(bus.pc), 32'(0));
    chk("rst_halted", 32'(bus.halted), 32'(0));
    chk("rst_illegal", 32'(bus.illegal_op), 32'(0));
    chk("rst_alu_opcode", 32'(bus.alu_opcode), 32'(0));
    chk("rst_alu_ops", 32'({bus.alu_operand1, bus.alu_operand2, bus.alu_param}), 32'(0));
    chk("rst_status", 32'(bus.status), 32'(0));
    reset = 1'b0;
    model_reset();
  endtask

  // Fetch with 'waits' stall cycles, then follow the instruction through
  task automatic run_instr(input logic [15:0] ins, input int waits);
    int n;
    logic [2:0] rd, rs;
    rd = ins[10:8]; rs = ins[2:0];
    n = 0;
    while (bus.prog_req !== 1'b1 && n < 8) begin
      @(posedge clock); @(negedge clock); n++;
    end
    chk("fetch_req", 32'(bus.prog_req), 32'(1));
    for (int i = 0; i < waits; i++) begin
      bus.prog_valid = 1'b0; bus.prog_data = 16'($urandom);
      @(posedge clock); @(negedge clock);
      chk("stall_req", 32'(bus.prog_req), 32'(1));
      chk("stall_pc", 32'(bus.pc), 32'(m_pc));
      chk("stall_opcode", 32'(bus.alu_opcode), 32'(0));
    end
    chk("fetch_addr", 32'(bus.prog_addr), 32'(m_pc));
    bus.prog_valid = 1'b1; bus.prog_data = ins;
    @(posedge clock); @(negedge clock);
    bus.prog_valid = 1'($urandom); bus.prog_data = 16'($urandom);
    chk("decode_opcode", 32'(bus.alu_opcode), 32'(0));
    chk("decode_req", 32'(bus.prog_req), 32'(0));
    @(posedge clock); @(negedge clock);
    chk("exec_opcode", 32'(bus.alu_opcode), 32'(ins[15:11]));
    chk("exec_op1", 32'(bus.alu_operand1), 32'(m_r[rd]));
    chk("exec_op2", 32'(bus.alu_operand2), 32'(m_r[rs]));
    chk("exec_param", 32'(bus.alu_param), 32'(ins[7:0]));
    last_op1 = bus.alu_operand1;
    model_step(ins);
    @(posedge clock); @(negedge clock);
    bus.prog_valid = 1'b0;
    chk("post_pc", 32'(bus.pc), 32'(m_pc));
    chk("post_status", 32'(bus.status), 32'(m_st));
    chk("post_halted", 32'(bus.halted), 32'(m_halt));
    chk("post_illegal", 32'(bus.illegal_op), 32'(m_ill));
    chk("post_req", 32'(bus.prog_req), 32'(!m_halt));
  endtask

  initial begin
    logic [4:0] op;
    logic [7:0] pc_before;
    reset = 1'b1;
    bus.prog_valid = 1'b0;
    bus.prog_data = 16'h0000;
    last_op1 = 8'h00;
    do_reset();

    // VAL R1,5; VAL R2,3; ADD R1,R2
    run_instr(enc(5'h09, 3'd1, 8'h05), 0);
    run_instr(enc(5'h09, 3'd2, 8'h03), 0);
    run_instr(enc(5'h01, 3'd1, 8'h02), 0);
    chk("add_pc", 32'(bus.pc), 32'(3));
    chk("add_status", 32'(bus.status), 32'(0));
    run_instr(enc(5'h00, 3'd1, 8'h01), 0);
    chk("add_r1", 32'(last_op1), 32'h08);

    // Carry out of ADD, then IFZ taken
    run_instr(enc(5'h09, 3'd1, 8'hFF), 0);
    run_instr(enc(5'h09, 3'd2, 8'h01), 0);
    run_instr(enc(5'h01, 3'd1, 8'h02), 0);
    chk("carry_status", 32'(bus.status), 32'(1));
    run_instr(enc(5'h11, 3'd1, 8'h40), 0);
    chk("ifz_r1", 32'(last_op1), 32'(0));
    chk("ifz_pc", 32'(bus.pc), 32'h40);

    // Delayed prog_valid
    run_instr(enc(5'h09, 3'd4, 8'h5A), 4);
    run_instr(enc(5'h00, 3'd4, 8'h00), 3);
    chk("stall_r4", 32'(last_op1), 32'h5A);

    // PC wrap
    run_instr(enc(5'h10, 3'd0, 8'hFF), 1);
    chk("goto_pc", 32'(bus.pc), 32'hFF);
    run_instr(enc(5'h00, 3'd0, 8'h00), 0);
    chk("wrap_pc", 32'(bus.pc), 32'h00);

    // Random instruction stream
    for (int k = 0; k < 60; k++) begin
      op = 5'($urandom_range(0, 31));
`ifdef JAC_HALT_ON_ILLEGAL_EN
      if ((op >= 5'h0A && op <= 5'h0F) || op >= 5'h16) op = 5'h01;
`endif
      run_instr(enc(op, 3'($urandom), 8'($urandom)), int'($urandom_range(0, 2)));
    end

    // Reserved opcode 0x0A
    pc_before = m_pc;
    run_instr(enc(5'h0A, 3'd0, 8'h00), 0);
`ifdef JAC_HALT_ON_ILLEGAL_EN
    chk("illegal_halted", 32'(bus.halted), 32'(1));
    chk("illegal_pulse", 32'(bus.illegal_op), 32'(1));
    for (int i = 0; i < 3; i++) begin
      bus.prog_valid = 1'b1; bus.prog_data = 16'($urandom);
      @(posedge clock); @(negedge clock);
      chk("halt_stays", 32'(bus.halted), 32'(1));
      chk("halt_pulse_end", 32'(bus.illegal_op), 32'(0));
      chk("halt_no_req", 32'(bus.prog_req), 32'(0));
      chk("halt_pc", 32'(bus.pc), 32'(pc_before));
    end
    bus.prog_valid = 1'b0;
`else
    chk("reserved_pc", 32'(bus.pc), 32'(8'(pc_before + 8'd1)));
    chk("reserved_no_illegal", 32'(bus.illegal_op), 32'(0));
`endif

    // Reset while executing VAL R3 discards it
    do_reset();
    run_instr(enc(5'h09, 3'd3, 8'h77), 0);
    bus.prog_valid = 1'b1; bus.prog_data = enc(5'h09, 3'd3, 8'h11);
    @(posedge clock); @(negedge clock);
    bus.prog_valid = 1'b0;
    @(posedge clock); @(negedge clock);
    chk("mid_exec_opcode", 32'(bus.alu_opcode), 32'h09);
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    chk("mid_rst_pc", 32'(bus.pc), 32'(0));
    chk("mid_rst_opcode", 32'(bus.alu_opcode), 32'(0));
    chk("mid_rst_req", 32'(bus.prog_req), 32'(0));
    reset = 1'b0;
    model_reset();
    run_instr(enc(5'h00, 3'd3, 8'h03), 0);
    chk("mid_rst_r3", 32'(last_op1), 32'(0));
    chk("mid_rst_pc_after", 32'(bus.pc), 32'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/jac_control_unit.md
JAC_CONTROL_UNIT -- requirements
Module: jac_control_unit

Interface
REQ-001 Parameter DataWidth, default 8, SHALL set register and ALU operand width.
REQ-002 Parameter NumOpCodeBits, default 5, SHALL set opcode field width.
REQ-003 Parameter ParamBits, default 8, SHALL set the immediate/target field width.
REQ-004 Parameter AddrWidth, default 8, SHALL set program counter width.
REQ-005 clock  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006 reset  in  1  SHALL be the reset, synchronous and active-high.
REQ-007 prog_req  out  1  SHALL request an instruction word at prog_addr.
REQ-008 prog_addr  out  AddrWidth  SHALL carry the fetch address (current PC).
REQ-009 prog_data  in  16  SHALL carry the instruction: [15:11] opcode, [10:8] rd, [7:0] param.
REQ-010 prog_valid  in  1  SHALL qualify prog_data; sampled only while prog_req is high.
REQ-011 alu_opcode  out  NumOpCodeBits  SHALL drive the ALU opcode.
REQ-012 alu_operand1 / alu_operand2  out  DataWidth each  SHALL drive R[rd] and R[param[2:0]].
REQ-013 alu_param  out  ParamBits  SHALL drive the latched param field.
REQ-014 alu_result / alu_status  in  DataWidth / 2  SHALL be the combinational ALU result and {underflow, carry}.
REQ-015 pc  out  AddrWidth  SHALL expose the current PC.
REQ-016 halted  out  1  SHALL be high while in HALT.
REQ-017 illegal_op  out  1  SHALL pulse one cycle on entry to HALT from a reserved opcode.

Function
REQ-018 FSM SHALL have states FETCH, DECODE, EXECUTE, HALT.
REQ-019 FETCH: prog_req high until prog_valid; on prog_valid latch prog_data, go DECODE; else remain FETCH.
REQ-020 DECODE SHALL read R[rd] and R[param[2:0]] from the 8x8 register file and go EXECUTE.
REQ-021 EXECUTE SHALL hold alu_* stable for exactly one cycle, then go FETCH; minimum 3 cycles per instruction with zero-wait memory.
REQ-022 Opcodes 0x01-0x08 (ADD..SHR) SHALL write alu_result to R[rd], load the status register from alu_status, and set PC=PC+1.
REQ-023 NOP (0x00) SHALL only advance PC; VAL (0x09) SHALL write param to R[rd] without touching status.
REQ-024 GOTO (0x10) SHALL set PC=param unconditionally.
REQ-025 IFZ/IFNZ SHALL branch to param when R[rd]==0 / !=0; IFEQ/IFST/IFGT SHALL branch when R[rd] ==, <, > R0 (unsigned); untaken branches SHALL set PC=PC+1.
REQ-026 PC increment SHALL wrap 255->0 without flag; branch-to-self SHALL loop indefinitely.
REQ-027 alu_opcode SHALL be NOP (0) outside EXECUTE so the ALU result is never written spuriously.
REQ-028 prog_valid outside FETCH SHALL be ignored.

Reset
REQ-029 reset SHALL force FETCH, PC=0, all registers and status=0, prog_req=0 for that cycle, halted=0, illegal_op=0, alu_* =0.
REQ-030 reset mid-fetch or mid-execute SHALL discard the in-flight instruction with no writeback; only reset SHALL leave HALT.

Configuration
REQ-031 With JAC_HALT_ON_ILLEGAL_EN defined, reserved opcodes (0x0A-0x0F, 0x16-0x1F) in EXECUTE SHALL go HALT and pulse illegal_op.
REQ-032 Without JAC_HALT_ON_ILLEGAL_EN, reserved opcodes SHALL execute as NOP; illegal_op SHALL be tied 0.

Structure
REQ-033 Package jac_pkg SHALL hold opcode constants, the FSM state typedef, and instruction field positions, shared with ALU_J users.
REQ-034 Register file SHALL be sub-module jac_regfile (8 x DataWidth, two async reads, one sync write).

Verification
REQ-035 VAL R1,0x05; VAL R2,0x03; ADD R1,R2 -> R1=0x08, status=00, PC=3.
REQ-036 VAL R1,0xFF; VAL R2,0x01; ADD R1,R2 -> R1=0x00, status carry=1; then IFZ R1,0x40 -> PC=0x40.
REQ-037 prog_valid delayed 4 cycles -> prog_req held, PC unchanged, no writeback until valid.
REQ-038 GOTO 0xFF then NOP at 0xFF -> PC wraps to 0x00.
REQ-039 Opcode 0x0A with macro -> halted=1, illegal_op one pulse; without macro -> PC+1; reset asserted during EXECUTE -> PC=0, no register write.
